ioctl_rom_loader: RTL and testbench
===================================

Name: ioctl_rom_loader

Overview:
- Multi-region ROM image loader between hps_io ioctl download port and the machine's ROM/RAM stores.
- Splits a bundled file (e.g. BIND88) into NUM_REGIONS equal-size slots and forwards bytes to memory through a ready/valid write handshake, with back-pressure to hps_io.
- Holds the CPU in reset during and after a download, and reports per-region load status, byte count, checksum and size errors.
- Successor to the fixed single-file ROM hookup; generalised in region count, region size and file index.

Parameters:
- NUM_REGIONS, 4, number of ROM slots in the bundle; power of two, ≥2.
- REGION_AW, 15, byte-address width of one region (region size = 2^REGION_AW).
- FILE_INDEX, 8'h01, ioctl_index value this loader accepts; all other indices are ignored.
- HOLD_CYCLES, 256, clk_sys cycles cpu_hold stays high after the last write completes; ≥1.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- ioctl_download  in  1  download active, from hps_io.
- ioctl_index  in  8  file index, from hps_io.
- ioctl_wr  in  1  one-cycle byte strobe, from hps_io.
- ioctl_addr  in  25  byte offset in file.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  back-pressure to hps_io.
- mem_wr  out  1  write valid.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_region  out  $clog2(NUM_REGIONS)  target slot.
- mem_addr  out  REGION_AW  byte address in slot.
- mem_data  out  8  write data.
- cpu_hold  out  1  CPU reset request, OR'd into core reset.
- region_loaded  out  NUM_REGIONS  slot received its last byte (offset 2^REGION_AW−1).
- load_done  out  1  one-cycle pulse at end of download.
- load_error  out  1  sticky until next accepted download start.
- byte_count  out  25  bytes accepted in the current or last download.
- checksum  out  16  modular 16-bit sum of accepted bytes.

Behaviour:
- Clock and reset: clk_sys only; reset is synchronous and active-high.
- Reset values: all outputs 0 except cpu_hold=1; state returns to HOLD with the counter loaded to HOLD_CYCLES.
- Download qualifier: accepted = ioctl_download && ioctl_index==FILE_INDEX. Non-matching downloads never affect outputs.
- States:
  - IDLE → LOAD on rising edge of accepted. Actions: cpu_hold=1; clear byte_count, checksum, region_loaded, load_error.
  - LOAD: each ioctl_wr captures addr/data into a one-entry buffer.
    - mem_wr rises the next cycle.
    - mem_region = ioctl_addr[REGION_AW +: RSEL_W]; mem_addr = ioctl_addr[REGION_AW-1:0].
    - mem_wr, mem_region, mem_addr and mem_data hold stable until the mem_wr && mem_ready cycle.
    - ioctl_wait=1 while the buffer is full.
    - byte_count increments and checksum adds on acceptance. Checksum wraps modulo 2^16; byte_count saturates at all-ones.
    - Address beyond NUM_REGIONS·2^REGION_AW: byte is dropped (no mem_wr), load_error=1, byte_count still increments.
    - ioctl_wr while the buffer is full and ioctl_wait is already high: protocol violation, byte dropped, load_error=1.
  - LOAD → FLUSH on falling edge of accepted.
  - FLUSH: wait until the buffer is empty.
  - FLUSH → HOLD: load counter with HOLD_CYCLES. If byte_count < 2^REGION_AW, set load_error.
  - HOLD: count down; cpu_hold=1.
  - HOLD → DONE at 0: cpu_hold drops; load_done pulses for exactly that one cycle.
  - DONE behaves as IDLE. A new accepted download restarts from LOAD.
- Simultaneous events: ioctl_wr in the same cycle as the buffer drains is accepted with no ioctl_wait bubble (full-throughput pipelining). A write arriving with ioctl_download falling in the same cycle is still accepted.
- Reset mid-download: outputs go to reset values; remaining bytes of that download are ignored until the next rising edge of accepted.
- Power-up: cpu_hold releases after HOLD_CYCLES even with no download, so built-in ROMs boot.

Decomposition:
- Package pc8001m_loader_pkg:
  - state enum {IDLE, LOAD, FLUSH, HOLD, DONE}.
  - function rsel_w(NUM_REGIONS).
  - localparam FILE_INDEX_BIND88 = 8'h01.
- One sub-module, loader_wbuf: one-entry skid buffer carrying {region, addr, data} with valid/ready, producing ioctl_wait.

Test Plan:
- Reset, no download → cpu_hold=1 for exactly 256 cycles, then 0; load_done pulses once; load_error=0.
- Download index 1, 4×32768 bytes, mem_ready tied 1 → 131072 mem_wr; region_loaded=4'b1111; byte_count=131072; checksum equals the model sum mod 65536; ioctl_wait never high.
- Same download with mem_ready toggling 1-in-3 → ioctl_wait asserted; no byte lost or duplicated; mem_addr/mem_data stable while mem_wr && !mem_ready.
- Download index 2 → no mem_wr; cpu_hold unchanged; all status outputs unchanged.
- 100-byte file → region_loaded=0; load_error=1 after FLUSH. Byte at offset 0x20000 → dropped; load_error=1.
- Reset asserted at byte 5000 of a download → outputs reset; next accepted download loads cleanly with load_error=0.

Source files
------------

// File: rtl/pc8001m_loader_pkg.sv
// Shared definitions for the ioctl ROM loader.
//
// Contents:
//   loader_state_e     - loader FSM states
//   FILE_INDEX_BIND88  - ioctl_index of the bundled BIND88 ROM image
//   rsel_w()           - width of the region-select field for a region count
package pc8001m_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } loader_state_e;

    localparam logic [7:0] FILE_INDEX_BIND88 = 8'h01;

    // A single region would need a zero-width select field, so it is
    // clamped to one bit. Region counts are powers of two, so $clog2 is exact.
    function automatic int rsel_w(input int num_regions);
        if (num_regions <= 1) begin
            return 1;
        end
        return $clog2(num_regions);
    endfunction

endpackage

// File: rtl/loader_wbuf.sv
// One-entry write buffer between the ioctl byte strobe and the memory write port.
//
// Handshake: o_valid/i_ready form a valid/ready pair. A word transfers on
// every cycle where o_valid && i_ready. Once o_valid is high, o_valid and
// o_data stay constant until that transfer cycle. A new word is loaded
// when i_valid is high and the slot is empty or draining in the same cycle.
// This gives one write per cycle at full throughput.
//
// Ports:
//   i_clk, i_reset - clock, synchronous active-high reset
//   i_valid        - new word offered (caller must not offer while o_wait)
//   i_data         - word to store
//   o_wait         - slot is occupied and will not drain this cycle
//   o_valid        - slot holds a word (write valid toward memory)
//   o_data         - stored word
//   i_ready        - memory accepts the stored word this cycle
module loader_wbuf #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_wait,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_drain;
    logic         w_load;

    assign w_drain = r_valid && i_ready;
    // The slot is free when it is empty or being emptied this same cycle.
    assign w_load  = i_valid && (!r_valid || i_ready);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
        end
    end

    // A full slot that drains this cycle does not stall the producer.
    assign o_wait  = r_valid && !i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/ioctl_rom_loader.sv
// Multi-region ROM image loader between the hps_io ioctl download port and
// the machine's ROM/RAM stores.
//
// The bundled file is split into NUM_REGIONS equal slots of 2^REGION_AW
// bytes. Each byte goes through a one-entry write buffer to memory. The CPU
// is held in reset during a download and for HOLD_CYCLES afterwards. It is
// also held for HOLD_CYCLES after reset, so built-in ROMs boot with no
// download.
//
// Ports:
//   clk_sys, reset       - clock, synchronous active-high reset
//   ioctl_download/index - download active and file index from hps_io
//   ioctl_wr/addr/dout   - byte strobe, file offset and data from hps_io
//   ioctl_wait           - back-pressure to hps_io
//   mem_wr/mem_ready     - write valid/ready toward memory
//   mem_region/addr/data - target slot, byte address in slot, write data
//   cpu_hold             - CPU reset request
//   region_loaded        - per-slot "last byte written" flags
//   load_done            - one-cycle pulse when cpu_hold releases
//   load_error           - sticky: size/range/protocol error in last download
//   byte_count, checksum - bytes accepted and their 16-bit modular sum
//   dbg_state            - current FSM state
module ioctl_rom_loader
    import pc8001m_loader_pkg::*;
#(
    parameter int         NUM_REGIONS = 4,
    parameter int         REGION_AW   = 15,
    parameter logic [7:0] FILE_INDEX  = FILE_INDEX_BIND88,
    parameter int         HOLD_CYCLES = 256,
    localparam int        RSEL_W      = rsel_w(NUM_REGIONS)
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   ioctl_download,
    input  logic [7:0]             ioctl_index,
    input  logic                   ioctl_wr,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    output logic                   ioctl_wait,
    output logic                   mem_wr,
    input  logic                   mem_ready,
    output logic [RSEL_W-1:0]      mem_region,
    output logic [REGION_AW-1:0]   mem_addr,
    output logic [7:0]             mem_data,
    output logic                   cpu_hold,
    output logic [NUM_REGIONS-1:0] region_loaded,
    output logic                   load_done,
    output logic                   load_error,
    output logic [24:0]            byte_count,
    output logic [15:0]            checksum,
    output loader_state_e          dbg_state
);

    localparam int              HC_W      = $clog2(HOLD_CYCLES + 1);
    localparam int              BUF_W     = RSEL_W + REGION_AW + 8;
    localparam int              SPAN_AW   = REGION_AW + RSEL_W;
    localparam logic [24:0]     MIN_BYTES = 25'(1) << REGION_AW;
    localparam logic [HC_W-1:0] HOLD_INIT = HC_W'(HOLD_CYCLES);

    loader_state_e        r_state;
    loader_state_e        w_state_nxt;

    logic                 r_acc_prev;
    logic [HC_W-1:0]      r_hold_cnt;
    logic [24:0]          r_byte_count;
    logic [15:0]          r_checksum;
    logic [NUM_REGIONS-1:0] r_region_loaded;
    logic                 r_load_error;
    logic                 r_load_done;

    logic                 w_accepted;
    logic                 w_acc_rise;
    logic                 w_acc_fall;
    logic                 w_loading;
    logic                 w_take;
    logic                 w_violation;
    logic                 w_oor;
    logic                 w_push;
    logic                 w_buf_wait;
    logic                 w_buf_valid;
    logic [BUF_W-1:0]     w_buf_in;
    logic [BUF_W-1:0]     w_buf_out;
    logic                 w_mem_fire;

    // FSM outputs
    logic                 w_start;
    logic                 w_flush_done;
    logic                 w_hold_dec;
    logic                 w_finish;
    logic                 w_cpu_hold;

    assign w_accepted = ioctl_download && (ioctl_index == FILE_INDEX);
    assign w_acc_rise = w_accepted && !r_acc_prev;
    assign w_acc_fall = !w_accepted && r_acc_prev;

    // Strobes are not qualified by ioctl_download, so a final byte
    // that arrives in the same cycle the download drops is still taken.
    assign w_loading   = (r_state == LOAD);
    assign w_take      = w_loading && ioctl_wr && !w_buf_wait;
    assign w_violation = w_loading && ioctl_wr && w_buf_wait;
    assign w_oor       = (ioctl_addr >> SPAN_AW) != 25'd0;
    assign w_push      = w_take && !w_oor;

    assign w_buf_in = {ioctl_addr[REGION_AW +: RSEL_W], ioctl_addr[REGION_AW-1:0], ioctl_dout};

    loader_wbuf #(
        .W(BUF_W)
    ) u_wbuf (
        .i_clk   (clk_sys),
        .i_reset (reset),
        .i_valid (w_push),
        .i_data  (w_buf_in),
        .o_wait  (w_buf_wait),
        .o_valid (w_buf_valid),
        .o_data  (w_buf_out),
        .i_ready (mem_ready)
    );

    assign {mem_region, mem_addr, mem_data} = w_buf_out;
    assign mem_wr     = w_buf_valid;
    assign ioctl_wait = w_buf_wait;
    assign w_mem_fire = w_buf_valid && mem_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_flush_done = 1'b0;
        w_hold_dec   = 1'b0;
        w_finish     = 1'b0;
        w_cpu_hold   = 1'b1;

        case (r_state)
            IDLE, DONE: begin
                w_cpu_hold = 1'b0;
                if (w_acc_rise) begin
                    w_state_nxt = LOAD;
                    w_start     = 1'b1;
                end
            end

            LOAD: begin
                if (w_acc_fall) begin
                    w_state_nxt = FLUSH;
                end
            end

            FLUSH: begin
                if (!w_buf_valid) begin
                    w_state_nxt  = HOLD;
                    w_flush_done = 1'b1;
                end
            end

            HOLD: begin
                // A download that starts while the CPU is still held
                // restarts the load instead of being missed.
                if (w_acc_rise) begin
                    w_state_nxt = LOAD;
                    w_start     = 1'b1;
                end else if (r_hold_cnt <= HC_W'(1)) begin
                    w_state_nxt = DONE;
                    w_finish    = 1'b1;
                end else begin
                    w_hold_dec = 1'b1;
                end
            end

            default: begin
                w_state_nxt = HOLD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Status and hold counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // The previous-accepted flag is forced high, so a download that
            // is already running when reset is released is not re-detected
            // as a new start.
            r_acc_prev      <= 1'b1;
            r_hold_cnt      <= HOLD_INIT;
            r_byte_count    <= '0;
            r_checksum      <= '0;
            r_region_loaded <= '0;
            r_load_error    <= 1'b0;
            r_load_done     <= 1'b0;
        end else begin
            r_acc_prev  <= w_accepted;
            r_load_done <= w_finish;

            if (w_flush_done) begin
                r_hold_cnt <= HOLD_INIT;
            end else if (w_hold_dec) begin
                r_hold_cnt <= r_hold_cnt - HC_W'(1);
            end

            if (w_start) begin
                r_byte_count    <= '0;
                r_checksum      <= '0;
                r_region_loaded <= '0;
                r_load_error    <= 1'b0;
            end else begin
                // Out-of-range bytes still count and add to the sum.
                // They are only kept away from memory.
                if (w_take) begin
                    if (r_byte_count != '1) begin
                        r_byte_count <= r_byte_count + 25'd1;
                    end
                    r_checksum <= r_checksum + 16'(ioctl_dout);
                end

                if ((w_take && w_oor) || w_violation) begin
                    r_load_error <= 1'b1;
                end

                if (w_flush_done && (r_byte_count < MIN_BYTES)) begin
                    r_load_error <= 1'b1;
                end

                if (w_mem_fire && (&mem_addr)) begin
                    r_region_loaded[mem_region] <= 1'b1;
                end
            end
        end
    end

    assign cpu_hold      = w_cpu_hold;
    assign load_done     = r_load_done;
    assign load_error    = r_load_error;
    assign byte_count    = r_byte_count;
    assign checksum      = r_checksum;
    assign region_loaded = r_region_loaded;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// Testbench for ioctl_rom_loader. It uses a reduced region size (256 bytes),
// so full four-region images stay short.
module tb_ioctl_rom_loader;
    import pc8001m_loader_pkg::*;

    localparam int NR   = 4;
    localparam int RAW  = 8;
    localparam int HOLD_N = 256;
    localparam int FULL = NR * (1 << RAW);   // 1024 bytes

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        mem_wr;
    logic        mem_ready;
    logic [1:0]  mem_region;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        cpu_hold;
    logic [3:0]  region_loaded;
    logic        load_done;
    logic        load_error;
    logic [24:0] byte_count;
    logic [15:0] checksum;
    loader_state_e dbg_state;

    ioctl_rom_loader #(
        .NUM_REGIONS(NR),
        .REGION_AW  (RAW),
        .FILE_INDEX (8'h01),
        .HOLD_CYCLES(HOLD_N)
    ) dut (
        .clk_sys       (clk),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_wait    (ioctl_wait),
        .mem_wr        (mem_wr),
        .mem_ready     (mem_ready),
        .mem_region    (mem_region),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .cpu_hold      (cpu_hold),
        .region_loaded (region_loaded),
        .load_done     (load_done),
        .load_error    (load_error),
        .byte_count    (byte_count),
        .checksum      (checksum),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    logic [17:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_hs = 0;
    int          ready_mode = 0;     // 0: always ready, 1: ready 1-in-3, 2: never
    bit          wait_seen = 0;
    bit          prev_stall = 0;
    logic [17:0] prev_word = '0;
    logic [24:0] m_count;
    logic [15:0] m_sum;
    logic [3:0]  m_loaded;

    // Memory-side monitor: choose mem_ready, then check the handshake.
    always @(negedge clk) begin
        logic [17:0] got;
        logic [17:0] exp;
        if (ready_mode == 0)      mem_ready = 1'b1;
        else if (ready_mode == 1) mem_ready = ($urandom_range(0, 2) == 0);
        else                      mem_ready = 1'b0;
        #1;
        got = {mem_region, mem_addr, mem_data};
        if (ioctl_wait) wait_seen = 1'b1;
        if (prev_stall && !reset) begin
            n_checks++;
            if (mem_wr !== 1'b1 || got !== prev_word) begin
                n_errors++;
                $display("FAIL stall_stable: mem_wr=%b word=%h, required mem_wr=1 word=%h", mem_wr, got, prev_word);
            end
        end
        if (mem_wr === 1'b1 && mem_ready) begin
            n_hs++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL mem_write_unexpected: word=%h, required no write", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_errors++;
                    $display("FAIL mem_write: word=%h, required %h", got, exp);
                end
            end
        end
        prev_stall = (mem_wr === 1'b1) && !mem_ready && !reset;
        prev_word  = got;
    end

    // ---------------- driver tasks ----------------
    task automatic model_clear();
        m_count  = '0;
        m_sum    = '0;
        m_loaded = '0;
    endtask

    task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
        m_count = m_count + 25'd1;
        m_sum   = m_sum + 16'(d);
        if (a < 25'(FULL)) begin
            exp_q.push_back({a[9:8], a[7:0], d});
            if (a[7:0] == 8'hff) m_loaded[a[9:8]] = 1'b1;
        end
    endtask

    task automatic put_byte(input logic [24:0] a, input logic [7:0] d, input bit last);
        int guard;
        guard = 0;
        while (ioctl_wait && guard < 200) begin
            @(negedge clk); #2;
            guard++;
        end
        if (ioctl_wait) begin
            n_checks++;
            n_errors++;
            $display("FAIL put_byte_wait_timeout: ioctl_wait=%b, required 0", ioctl_wait);
        end
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (last) ioctl_download = 1'b0;
        @(negedge clk); #2;
        ioctl_wr = 1'b0;
    endtask

    task automatic start_download(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(negedge clk); #2;
        @(negedge clk); #2;
    endtask

    task automatic send_bytes(input int nbytes, input bit match, input bit end_file);
        logic [24:0] a;
        logic [7:0]  d;
        for (int i = 0; i < nbytes; i++) begin
            a = 25'(i);
            d = 8'($urandom_range(0, 255));
            if (match) model_byte(a, d);
            put_byte(a, d, end_file && (i == nbytes - 1));
        end
    endtask

    task automatic wait_done(input string tag);
        int g;
        g = 0;
        while (load_done !== 1'b1 && g < 3000) begin
            @(negedge clk); #2;
            g++;
        end
        n_checks++;
        if (load_done !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_done_timeout: load_done=%b after %0d cycles, required 1", tag, load_done, g);
        end
        @(negedge clk); #2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int held;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        n_checks++;
        if (cpu_hold !== 1'b1 || mem_wr !== 1'b0 || ioctl_wait !== 1'b0 || load_done !== 1'b0 ||
            load_error !== 1'b0 || byte_count !== 25'd0 || checksum !== 16'd0 || region_loaded !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_values: hold=%b wr=%b wait=%b done=%b err=%b cnt=%0d sum=%h loaded=%b, required 1 0 0 0 0 0 0000 0000",
                     cpu_hold, mem_wr, ioctl_wait, load_done, load_error, byte_count, checksum, region_loaded);
        end
        n_checks++;
        if (dbg_state !== HOLD) begin
            n_errors++;
            $display("FAIL reset_state: state=%0d, required %0d", dbg_state, HOLD);
        end
        reset = 1'b0;
        held = 0;
        while (cpu_hold === 1'b1 && held < 1000) begin
            held++;
            @(negedge clk); #2;
        end
        n_checks++;
        if (held != HOLD_N) begin
            n_errors++;
            $display("FAIL powerup_hold_len: held %0d cycles, required %0d", held, HOLD_N);
        end
        n_checks++;
        if (load_done !== 1'b1) begin
            n_errors++;
            $display("FAIL powerup_done_pulse: load_done=%b, required 1", load_done);
        end
        @(negedge clk); #2;
        n_checks++;
        if (load_done !== 1'b0 || load_error !== 1'b0 || cpu_hold !== 1'b0) begin
            n_errors++;
            $display("FAIL powerup_after: done=%b err=%b hold=%b, required 0 0 0", load_done, load_error, cpu_hold);
        end
    endtask

    task automatic check_full_result(input string tag, input int hs0);
        n_checks++;
        if (n_hs - hs0 != FULL) begin
            n_errors++;
            $display("FAIL %s_writes: %0d mem writes, required %0d", tag, n_hs - hs0, FULL);
        end
        n_checks++;
        if (byte_count !== 25'(FULL) || checksum !== m_sum) begin
            n_errors++;
            $display("FAIL %s_count_sum: cnt=%0d sum=%h, required %0d %h", tag, byte_count, checksum, FULL, m_sum);
        end
        n_checks++;
        if (region_loaded !== 4'b1111 || load_error !== 1'b0 || cpu_hold !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_status: loaded=%b err=%b hold=%b, required 1111 0 0", tag, region_loaded, load_error, cpu_hold);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_queue: %0d writes missing, required 0", tag, exp_q.size());
        end
    endtask

    task automatic test_full_load();
        int hs0;
        ready_mode = 0;
        model_clear();
        hs0 = n_hs;
        wait_seen = 1'b0;
        start_download(8'h01);
        n_checks++;
        if (cpu_hold !== 1'b1 || dbg_state !== LOAD) begin
            n_errors++;
            $display("FAIL full_hold_in_load: hold=%b state=%0d, required 1 %0d", cpu_hold, dbg_state, LOAD);
        end
        send_bytes(FULL, 1'b1, 1'b1);
        wait_done("full");
        check_full_result("full", hs0);
        n_checks++;
        if (wait_seen) begin
            n_errors++;
            $display("FAIL full_no_wait: ioctl_wait seen=1, required 0");
        end
    endtask

    task automatic test_backpressure();
        int hs0;
        ready_mode = 1;
        model_clear();
        hs0 = n_hs;
        wait_seen = 1'b0;
        start_download(8'h01);
        send_bytes(FULL, 1'b1, 1'b1);
        ready_mode = 0;
        wait_done("bp");
        check_full_result("bp", hs0);
        n_checks++;
        if (!wait_seen) begin
            n_errors++;
            $display("FAIL bp_wait_seen: ioctl_wait seen=0, required 1");
        end
    endtask

    task automatic test_other_index();
        int hs0;
        int bad;
        hs0 = n_hs;
        bad = 0;
        start_download(8'h02);
        send_bytes(50, 1'b0, 1'b1);
        repeat (300) begin
            if (cpu_hold !== 1'b0 || load_done !== 1'b0) bad++;
            @(negedge clk); #2;
        end
        n_checks++;
        if (bad != 0 || n_hs != hs0) begin
            n_errors++;
            $display("FAIL other_idx_quiet: hold/done cycles=%0d writes=%0d, required 0 0", bad, n_hs - hs0);
        end
        n_checks++;
        if (byte_count !== m_count || checksum !== m_sum || region_loaded !== m_loaded || load_error !== 1'b0) begin
            n_errors++;
            $display("FAIL other_idx_status: cnt=%0d sum=%h loaded=%b err=%b, required %0d %h %b 0",
                     byte_count, checksum, region_loaded, load_error, m_count, m_sum, m_loaded);
        end
    endtask

    task automatic test_short_file();
        model_clear();
        start_download(8'h01);
        send_bytes(100, 1'b1, 1'b0);
        n_checks++;
        if (load_error !== 1'b0) begin
            n_errors++;
            $display("FAIL short_err_early: load_error=%b, required 0", load_error);
        end
        ioctl_download = 1'b0;
        wait_done("short");
        n_checks++;
        if (load_error !== 1'b1 || region_loaded !== 4'b0000 || byte_count !== 25'd100 || checksum !== m_sum) begin
            n_errors++;
            $display("FAIL short_status: err=%b loaded=%b cnt=%0d sum=%h, required 1 0000 100 %h",
                     load_error, region_loaded, byte_count, checksum, m_sum);
        end
    endtask

    task automatic test_out_of_range();
        int hs0;
        model_clear();
        hs0 = n_hs;
        start_download(8'h01);
        send_bytes(4, 1'b1, 1'b0);
        n_checks++;
        if (load_error !== 1'b0) begin
            n_errors++;
            $display("FAIL oor_err_before: load_error=%b, required 0", load_error);
        end
        model_byte(25'h400, 8'h5a);
        put_byte(25'h400, 8'h5a, 1'b0);
        n_checks++;
        if (load_error !== 1'b1 || byte_count !== 25'd5 || checksum !== m_sum || dbg_state !== LOAD) begin
            n_errors++;
            $display("FAIL oor_status: err=%b cnt=%0d sum=%h state=%0d, required 1 5 %h %0d",
                     load_error, byte_count, checksum, dbg_state, m_sum, LOAD);
        end
        ioctl_download = 1'b0;
        wait_done("oor");
        n_checks++;
        if (n_hs - hs0 != 4 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL oor_writes: %0d writes, %0d pending, required 4 0", n_hs - hs0, exp_q.size());
        end
    endtask

    task automatic test_protocol_violation();
        int hs0;
        model_clear();
        hs0 = n_hs;
        start_download(8'h01);
        ready_mode = 2;
        model_byte(25'd0, 8'h11);
        put_byte(25'd0, 8'h11, 1'b0);
        // Buffer is full and memory is stalled: this strobe ignores ioctl_wait.
        ioctl_addr = 25'd1;
        ioctl_dout = 8'h22;
        ioctl_wr   = 1'b1;
        @(negedge clk); #2;
        ioctl_wr = 1'b0;
        n_checks++;
        if (load_error !== 1'b1 || byte_count !== 25'd1 || checksum !== 16'h0011) begin
            n_errors++;
            $display("FAIL proto_status: err=%b cnt=%0d sum=%h, required 1 1 0011", load_error, byte_count, checksum);
        end
        ready_mode = 0;
        @(negedge clk); #2;
        ioctl_download = 1'b0;
        wait_done("proto");
        n_checks++;
        if (n_hs - hs0 != 1 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL proto_writes: %0d writes, %0d pending, required 1 0", n_hs - hs0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_download();
        int hs0;
        model_clear();
        start_download(8'h01);
        send_bytes(300, 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk); #2;
        @(negedge clk); #2;
        n_checks++;
        if (cpu_hold !== 1'b1 || mem_wr !== 1'b0 || byte_count !== 25'd0 || checksum !== 16'd0 ||
            region_loaded !== 4'd0 || load_error !== 1'b0 || ioctl_wait !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_values: hold=%b wr=%b cnt=%0d sum=%h loaded=%b err=%b wait=%b, required 1 0 0 0000 0000 0 0",
                     cpu_hold, mem_wr, byte_count, checksum, region_loaded, load_error, ioctl_wait);
        end
        reset = 1'b0;
        exp_q.delete();
        hs0 = n_hs;
        // Rest of the interrupted download must be ignored.
        send_bytes(20, 1'b0, 1'b0);
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        n_checks++;
        if (n_hs != hs0 || byte_count !== 25'd0) begin
            n_errors++;
            $display("FAIL midreset_ignored: writes=%0d cnt=%0d, required 0 0", n_hs - hs0, byte_count);
        end
        wait_done("midreset_hold");
        model_clear();
        hs0 = n_hs;
        start_download(8'h01);
        send_bytes(FULL, 1'b1, 1'b1);
        wait_done("reload");
        check_full_result("reload", hs0);
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        mem_ready      = 1'b1;
        model_clear();

        test_reset();
        test_full_load();
        test_backpressure();
        test_other_index();
        test_short_file();
        test_out_of_range();
        test_protocol_violation();
        test_reset_mid_download();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
